// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, constants and sample-point helper for the UART path.
package uart_pkg;

  localparam int unsigned SYNC_STAGES      = 2;
  localparam int unsigned MIN_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

  // Clocks from the detected start edge to the centre of the start bit.
  function automatic int unsigned mid_bit(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count and overrun pulse.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overrun
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overrun;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW + 1)'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // The same-cycle pop frees the slot this push needs.
  assign w_push  = i_push & (~w_full | w_pop);

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_push & w_full & ~w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid   = ~w_empty;
  assign o_count   = r_count;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (start + DATA_BITS LSB-first + stop) feeding a receive FIFO.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 218,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD   = 0
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rxd,
  input  logic                        rd_en,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        parity_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LP_MID      = CW'(mid_bit(CLKS_PER_BIT));
  localparam logic [CW-1:0] LP_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LP_IDX_LAST = IW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_cpb_check
    $error("CLKS_PER_BIT must be at least %0d", MIN_CLKS_PER_BIT);
  end

  logic [SYNC_STAGES-1:0] r_sync;
  rx_state_e              r_state;
  logic [CW-1:0]          r_bit_cnt;
  logic [IW-1:0]          r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_frame_err;
  logic                   w_rxd_s;
  logic                   w_push;
  logic                   w_stop_sample;

  assign w_rxd_s       = r_sync[SYNC_STAGES-1];
  assign w_stop_sample = (r_state == StStop) && (r_bit_cnt == LP_LAST);
  assign w_push        = w_stop_sample & w_rxd_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  logic w_par_bad;

  // Data bits plus parity bit must have even (or odd) weight.
  assign w_par_bad = ((^r_shift) ^ r_par_bit) != 1'(PARITY_ODD);

  // Capture the parity bit and report a mismatch at the stop-bit sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_stop_sample & w_par_bad;
      if ((r_state == StParity) && (r_bit_cnt == LP_LAST)) begin
        r_par_bit <= w_rxd_s;
      end
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // Receive FSM: all samples taken at bit centres aligned from the start-bit midpoint.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (!w_rxd_s) begin
            r_state   <= StStart;
            r_bit_cnt <= '0;
          end
        end
        StStart: begin
          if (r_bit_cnt == LP_MID) begin
            r_bit_cnt <= '0;
            r_idx     <= '0;
            // A high line at mid-start is a glitch, not a frame.
            r_state   <= w_rxd_s ? StIdle : StData;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        StData: begin
          if (r_bit_cnt == LP_LAST) begin
            r_bit_cnt <= '0;
            r_shift   <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
            r_idx     <= r_idx + IW'(1);
            if (r_idx == LP_IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= StParity;
`else
              r_state <= StStop;
`endif
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (r_bit_cnt == LP_LAST) begin
            r_bit_cnt <= '0;
            r_state   <= StStop;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
`endif
        StStop: begin
          if (r_bit_cnt == LP_LAST) begin
            r_bit_cnt <= '0;
            if (w_rxd_s) begin
              r_state <= StIdle;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= StWaitHigh;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        StWaitHigh: begin
          // Hold off through a break until the line returns high.
          if (w_rxd_s) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign frame_err = r_frame_err;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_data(r_shift),
    .i_pop      (rd_en),
    .o_head     (rd_data),
    .o_valid    (rd_valid),
    .o_count    (count),
    .o_overrun  (overrun)
  );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with an integrated receive FIFO. Successor to the SOC's fixed 8N1 receive path.
- Sits between the SOC RXD pin and the CPU memory-mapped UART register.
- Adds configurable baud divisor, data width and FIFO depth, false-start rejection, framing/overrun reporting and optional parity checking.
- The CPU drains received bytes at its own pace, so inter-byte gaps no longer matter.

Parameters:
- CLKS_PER_BIT, 218: clk cycles per UART bit. 10 MHz clk with a 21.8 us bit period. Must be >= 4.
- DATA_BITS, 8: data bits per frame, 5..8, sent LSB first.
- FIFO_DEPTH, 16: receive FIFO entries. Power of two, >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rxd  in  1  serial input. Asynchronous to clk; idle high.
- rd_en  in  1  pop the head entry. Ignored when rd_valid=0.
- rd_data  out  DATA_BITS  head of FIFO (first-word-fall-through).
- rd_valid  out  1  FIFO not empty.
- count  out  $clog2(FIFO_DEPTH)+1  number of entries held.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while FIFO full and no pop that cycle.
- parity_err  out  1  one-cycle pulse. Tied 0 unless UART_RX_PARITY_EN.

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE, synchroniser flops=1, FIFO empty.
  - rd_valid=0, count=0, rd_data=0, all error pulses 0.
- Input synchroniser: rxd passes through 2 flops; the FSM uses only the synchronised rxd_s.
- Bit counter: bit_cnt counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Index counter: 0..DATA_BITS-1.
- FSM states: IDLE, START, DATA, PARITY (only with the feature), STOP, WAIT_HIGH.
- IDLE: on rxd_s=0, go to START and clear bit_cnt.
- START: at bit_cnt=(CLKS_PER_BIT-1)/2 (mid-bit), sample rxd_s.
  - 1: false start, go to IDLE, no error.
  - 0: go to DATA, clear bit_cnt.
- DATA: sample at each bit_cnt=CLKS_PER_BIT-1 (mid-bit, aligned from START).
  - Shift samples into the shift register LSB first.
  - After DATA_BITS samples go to PARITY (feature on) or STOP.
- STOP: sample at mid-bit.
  - 1: push the byte and go to IDLE.
  - 0: pulse frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxd_s=1, then go to IDLE. This covers a break condition.
- Push latency: rd_valid and count update the cycle after the stop-bit sample.
- FIFO rules:
  - Pop on empty: no effect.
  - Push with FIFO full and rd_en=0: byte dropped, overrun pulses, contents unchanged.
  - Push with FIFO full and rd_en=1 in the same cycle: pop then push, byte accepted, count unchanged.
  - Push and pop together at any other level: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rd_data holds the head entry while rd_valid=1. Value is don't-care when empty.
- Reset mid-frame: the partial frame is discarded and the FSM returns to IDLE. If rxd is still low after reset, the next falling-to-low level is treated as a start bit. This is accepted behaviour.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even parity).
  - PARITY state samples one extra bit after DATA.
  - On mismatch, parity_err pulses in the STOP-sample cycle and the byte is still pushed. Software decides what to do with it.
- Undefined:
  - No PARITY state; frame is 1 start + DATA_BITS + 1 stop.
  - parity_err is tied 0.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum;
  - the constants SYNC_STAGES=2 and MIN_CLKS_PER_BIT=4;
  - the helper function for mid-bit sample point computation.
- Sub-module sync_fifo (WIDTH, DEPTH): holds the pointers, count, full/empty logic and the simultaneous push/pop rule. It will be reused by the future TX path.

Test Plan:
- Reset, idle line, send 0x35 at 218 clk/bit -> one stop-bit time later rd_valid=1, rd_data=0x35, count=1. rd_en for 1 cycle -> rd_valid=0, count=0.
- Send 0x35, 0x37, 0x38, 0x0D back-to-back with no reads -> count=4. Four pops return 0x35, 0x37, 0x38, 0x0D in order.
- Low glitch on rxd of 50 clks -> no push, no error. A following 0x41 is received correctly.
- Frame 0x55 with stop bit held low for 3 bit times -> frame_err single pulse, count stays 0. The next 0x33 is received.
- 17 frames of 0x00..0x10 with no reads -> count=16, overrun pulses on the 17th frame, head=0x00, tail=0x0F. Repeat with rd_en asserted in the 17th push cycle -> no overrun, tail=0x10.
- Assert reset midway through data bit 4 of 0x38 -> FIFO empty and FSM IDLE. A subsequent 0x38 is received intact.
